alu_seq_unit: RTL
=================

# alu_seq_unit

Parametrised, sequenced successor to the miniMIPS ALU control unit: decodes `alu_op`/`func` into a 3-bit `alu_ctr` and executes the operation on `WIDTH`-bit operands. Transactions enter through a valid/ready handshake and leave as a one-cycle `done` pulse. Single-cycle ops complete in 2 cycles; MUL runs as an iterative shift-add multiplier. The block sits in the EX stage of the multi-cycle datapath, between the main control FSM and the register write-back mux.

## Interface
- `WIDTH`, default 32: operand and result width (≥2).
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `in_valid`  in  1  request present.
- `in_ready`  out  1  block can accept a request; high only in IDLE.
- `alu_op`  in  3  main-control op class.
- `func`  in  3  R-type function field.
- `a`, `b`  in  WIDTH each  operands.
- `alu_ctr`  out  3  decoded control of the last accepted request (registered).
- `result`  out  WIDTH  result, held until the next `done`.
- `zero`  out  1  `result == 0`, registered with `result`.
- `done`  out  1  one-cycle pulse when `result`/`zero`/`err` are updated.
- `err`  out  1  illegal op; valid with `done`.

## Operation
- `alu_ctr` encoding: 000 AND, 001 OR, 010 ADD, 011 SUB, 100 SLT, 101 NOR, 110 MUL, 111 XOR.
- Decode when `alu_op`=000 (R-type): `alu_ctr` = `func`.
- Decode for other `alu_op` values: 001 ADD, 010 SUB, 011 AND, 100 OR, 101 SLT, 110 XOR, 111 NOR. These never yield MUL.
- Accept: on an edge where `in_valid && in_ready`, capture `a`, `b` and the decoded `alu_ctr`.
  - MUL goes to state MUL.
  - Every other op goes to state EXEC.
- EXEC (1 cycle): compute, register `result`/`zero`, pulse `done`, return to IDLE.
- MUL (`WIDTH` cycles):
  - Each cycle: if the multiplier LSB is set, `acc += mcand`; then `mcand <<= 1` and `mplier >>= 1`.
  - Step counter counts 0..WIDTH-1.
  - On the last step: `result` = low `WIDTH` bits of the unsigned product, pulse `done`, go to IDLE.
- Arithmetic:
  - ADD/SUB wrap modulo 2^WIDTH; no overflow flag.
  - SLT is signed two's complement; result is 1 or 0, zero-extended.
  - NOR is `~(a|b)`.
- `in_valid` while busy is ignored; no request is queued. The requester holds it until `in_ready`.
- `alu_ctr` is updated only at accept.

## Timing
- Reset values: `in_ready`=1 once reset is released; `alu_ctr`=000; `result`=0; `zero`=0; `done`=0; `err`=0; state IDLE; internal accumulators and counter = 0.
- Accept edge at the end of cycle 0:
  - Single-cycle op: `done` high in cycle 2.
  - MUL: `done` high in cycle WIDTH+1.
- `in_ready` rises in the same cycle as `done`. Back-to-back throughput is one request per 2 cycles (single) or WIDTH+1 cycles (MUL).
- `done` is high exactly one cycle per transaction.
- `reset` asserted mid-EXEC or mid-MUL: abort immediately with no `done`; all outputs return to reset values.
- `in_valid` with an X or unchanged `func`/`alu_op` while busy has no effect.

## Configuration
- `ALU_SEQ_MUL_EN` defined: MUL is implemented as described above.
- `ALU_SEQ_MUL_EN` undefined:
  - No MUL state and no multiplier datapath.
  - A MUL decode (`alu_op`=000, `func`=110) takes the EXEC path: `result`=0, `zero`=1, `err`=1 with `done` in cycle 2, `alu_ctr`=110.
  - `err` is otherwise always 0 in both builds.

## Test plan
- Reset then idle: `reset` pulse mid-cycle → all outputs 0 immediately, `in_ready`=1 after release, no `done`.
- R-type sweep (WIDTH=32), `a`=0x0000000C, `b`=0x0000000A, `func` 000,001,010,011,101,111 → `result` 0x8, 0xE, 0x16, 0x2, 0xFFFFFFF1, 0x6; each `done` 2 cycles after accept.
- `alu_op` class sweep:
  - `alu_op`=101, `a`=0xFFFFFFFF, `b`=1 → `result`=1 (signed SLT), `alu_ctr`=100.
  - `alu_op`=010, `a`=`b`=7 → `result`=0, `zero`=1.
- MUL (WIDTH=8, macro defined), `a`=13, `b`=11 → `result`=0x8F, `done` exactly 9 cycles after accept, `in_ready` low for cycles 1–8; `a`=0xFF, `b`=0xFF → `result`=0x01 (wrap).
- Busy handling: assert `in_valid` continuously during a MUL → no second accept until the `done` cycle, then the next request is accepted that cycle.
- Abort and no-MUL build:
  - Assert `reset` at MUL step 4 → no `done`, `result`=0.
  - Macro undefined, MUL request → `err`=1, `result`=0, `zero`=1 at cycle 2.

Source files
------------

// File: rtl/alu_seq_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : alu_seq_unit
// Purpose  : Sequenced EX-stage ALU. Decodes alu_op/func into a 3-bit alu_ctr,
//            accepts one request per valid/ready handshake and returns the
//            registered result with a one-cycle done pulse. Single-cycle ops
//            finish in 2 cycles; MUL is an iterative shift-add multiplier that
//            finishes in WIDTH+1 cycles.
// Ports    : clk, reset (async, active-high)
//            in_valid / in_ready   request handshake (ready only in IDLE)
//            alu_op[2:0], func[2:0] control fields; a, b operands
//            alu_ctr[2:0]          decoded control of last accepted request
//            result, zero, err     registered outcome, updated with done
//            done                  one-cycle completion pulse
// Config   : `define ALU_SEQ_MUL_EN to build the multiplier. Without it a MUL
//            decode completes on the EXEC path with result=0 and err=1.
// Revision : 1.0  initial release
// ============================================================================
module alu_seq_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       alu_op,
    input  logic [2:0]       func,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [2:0]       alu_ctr,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             done,
    output logic             err
);

    localparam logic [2:0] c_CTR_AND = 3'b000;
    localparam logic [2:0] c_CTR_OR  = 3'b001;
    localparam logic [2:0] c_CTR_ADD = 3'b010;
    localparam logic [2:0] c_CTR_SUB = 3'b011;
    localparam logic [2:0] c_CTR_SLT = 3'b100;
    localparam logic [2:0] c_CTR_NOR = 3'b101;
    localparam logic [2:0] c_CTR_MUL = 3'b110;
    localparam logic [2:0] c_CTR_XOR = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_MUL  = 2'd2
    } state_t;

    state_t           state_q;
    logic [2:0]       ctr_q;
    logic [WIDTH-1:0] opa_q;
    logic [WIDTH-1:0] opb_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             done_q;
    logic             err_q;

    logic [2:0]       ctr_d;
    logic [WIDTH-1:0] exec_res_d;
    logic             exec_err_d;

`ifdef ALU_SEQ_MUL_EN
    localparam int              c_CNT_W = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH - 1);

    // During MUL, opa_q is the left-shifting multiplicand and opb_q the
    // right-shifting multiplier, so no separate operand copies are kept.
    logic [WIDTH-1:0]   acc_q;
    logic [c_CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0]   acc_d;

    assign acc_d = acc_q + (opb_q[0] ? opa_q : '0);
`endif

    // Request decode; non-R-type classes can never produce MUL.
    always_comb begin
        ctr_d = func;
        case (alu_op)
            3'b000:  ctr_d = func;
            3'b001:  ctr_d = c_CTR_ADD;
            3'b010:  ctr_d = c_CTR_SUB;
            3'b011:  ctr_d = c_CTR_AND;
            3'b100:  ctr_d = c_CTR_OR;
            3'b101:  ctr_d = c_CTR_SLT;
            3'b110:  ctr_d = c_CTR_XOR;
            default: ctr_d = c_CTR_NOR;
        endcase
    end

    // Single-cycle datapath evaluated on the captured operands.
    always_comb begin
        exec_res_d = '0;
        exec_err_d = 1'b0;
        case (ctr_q)
            c_CTR_AND: exec_res_d = opa_q & opb_q;
            c_CTR_OR:  exec_res_d = opa_q | opb_q;
            c_CTR_ADD: exec_res_d = opa_q + opb_q;
            c_CTR_SUB: exec_res_d = opa_q - opb_q;
            c_CTR_SLT: exec_res_d = {{(WIDTH-1){1'b0}}, ($signed(opa_q) < $signed(opb_q))};
            c_CTR_NOR: exec_res_d = ~(opa_q | opb_q);
            c_CTR_XOR: exec_res_d = opa_q ^ opb_q;
            c_CTR_MUL: begin
                // Only reachable when the multiplier is not built.
`ifndef ALU_SEQ_MUL_EN
                exec_err_d = 1'b1;
`endif
            end
            default:   exec_res_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            ctr_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            acc_q    <= '0;
            cnt_q    <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        ctr_q <= ctr_d;
                        opa_q <= a;
                        opb_q <= b;
`ifdef ALU_SEQ_MUL_EN
                        if (ctr_d == c_CTR_MUL) begin
                            acc_q   <= '0;
                            cnt_q   <= '0;
                            state_q <= S_MUL;
                        end else begin
                            state_q <= S_EXEC;
                        end
`else
                        state_q <= S_EXEC;
`endif
                    end
                end
                S_EXEC: begin
                    result_q <= exec_res_d;
                    zero_q   <= (exec_res_d == '0);
                    err_q    <= exec_err_d;
                    done_q   <= 1'b1;
                    state_q  <= S_IDLE;
                end
`ifdef ALU_SEQ_MUL_EN
                S_MUL: begin
                    acc_q <= acc_d;
                    opa_q <= opa_q << 1;
                    opb_q <= opb_q >> 1;
                    if (cnt_q == c_LAST) begin
                        result_q <= acc_d;
                        zero_q   <= (acc_d == '0);
                        err_q    <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + c_CNT_W'(1);
                    end
                end
`endif
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready = (state_q == S_IDLE);
    assign alu_ctr  = ctr_q;
    assign result   = result_q;
    assign zero     = zero_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule
`default_nettype wire
